regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port (wEn1/wA1/wD1) of the 16x32 register file between NREQ
//  writeback requesters (default ALU and load unit) using round-robin arbitration.
//  Holds a per-register pending scoreboard so issue logic can stall on RAW hazards.
//  Filters writes to r15, which is the free-running counter owned by the register file.
//  Sits between the execute/memory writeback stages and the register file.
// PARAMETERS
//  NREQ  2   number of writeback requesters (2..4)
//  AW    4   register address width (16 registers)
//  DW    32  data width
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous, active-low reset
//  req_valid     in   NREQ      requester i has a write pending
//  req_addr      in   NREQ*AW   destination register; slice i = [i*AW +: AW]
//  req_data      in   NREQ*DW   write data; slice i = [i*DW +: DW]
//  req_ready     out  NREQ      one-hot grant; handshake completes when valid&ready
//  claim_valid   in   1         issue stage reserves a destination register
//  claim_addr    in   AW        register being reserved
//  wEn1          out  1         registered write enable to the register file
//  wA1           out  AW        registered write address
//  wD1           out  DW        registered write data
//  busy          out  16        scoreboard; bit r set = write to r outstanding
//  r15_drop      out  1         1-cycle pulse when an accepted write targeting r15 is discarded
// BEHAVIOUR
//  Reset (async, rst_n=0): wEn1=0, wA1=0, wD1=0, busy=0, r15_drop=0, rr_ptr=0.
//  Arbitration (combinational, no back-pressure from the register file):
//   - Exactly one grant per cycle when any req_valid is set; otherwise req_ready=0.
//   - Priority search starts at rr_ptr and wraps modulo NREQ. On a handshake,
//     rr_ptr <= granted index + 1 (mod NREQ). With no handshake, rr_ptr holds.
//   - req_ready depends on req_valid. A requester must not gate valid on ready.
//     Once valid is asserted, addr and data must stay stable until the handshake.
//  Write issue: the handshake in cycle N produces wEn1=1 with wA1/wD1 = granted addr/data
//   in cycle N+1. The register file commits at the end of N+1. Latency is 1 cycle.
//   - With no handshake in N, wEn1=0 in N+1. wA1 and wD1 hold their last values.
//   - A granted addr of 15 is accepted (req_ready=1), but wEn1=0 in N+1 and r15_drop=1 in N+1.
//  Scoreboard (busy):
//   - claim_valid sets busy[claim_addr] at the clock edge. A claim to r15 is ignored.
//   - Clear: busy[wA1] is cleared at the edge that ends a cycle with wEn1=1. This is the
//     same edge at which the register file commits, so busy=0 means the data is readable.
//   - A claim and a clear to the same register in the same cycle: the claim wins, and the
//     bit stays set for the newer producer.
//   - A dropped r15 write clears nothing.
//   - A writeback to a register that is not busy still writes. busy is unaffected.
//  Throughput: one write per cycle sustained. A requester waits at most NREQ-1 cycles.
//  Reset asserted mid-operation: any in-flight write in the output register is lost
//   (wEn1 forced to 0 immediately), and all busy bits clear.
// STRUCTURE
//  Shared package regfile_pkg: localparams RF_AW=4, RF_DW=32, RF_NREGS=16, RF_PC_IDX=15.
//  Sub-module rr_arbiter (NREQ): req vector plus advance strobe -> one-hot grant and
//   rotating pointer. Reusable by a later read-port arbiter.
//  This module contains the grant mux, the output register and the scoreboard register.
// TESTING
//  1 Reset: drive rst_n=0 mid-stream with wEn1=1 -> wEn1=0, busy=0 asynchronously,
//    without waiting for a clk edge.
//  2 Single write: req0 addr=3 data=32'hDEADBEEF in cycle N -> ready0=1 in N,
//    wEn1=1 wA1=3 wD1=DEADBEEF in N+1, r3 reads DEADBEEF in N+2.
//  3 Contention: both valid for 4 cycles (rr_ptr=0) -> grants 0,1,0,1.
//    Each requester changes addr after its handshake.
//  4 Scoreboard: claim r5 in cycle 0, then write r5 in cycle 3 -> busy[5]=1 in cycles 1..4,
//    busy[5]=0 in cycle 5. Claim r7 and clear r7 in the same cycle -> busy[7] stays 1.
//  5 r15 filter: req1 addr=15 -> ready1=1, wEn1=0 next cycle, r15_drop=1 pulse,
//    and r15 keeps incrementing by 1 per cycle.
//  6 Idle: no req_valid for 3 cycles -> wEn1=0 throughout, rr_ptr unchanged.
//    Next single request is granted in the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the writeback arbiter and later read-port logic.
package regfile_pkg;
  localparam int RF_AW     = 4;
  localparam int RF_DW     = 32;
  localparam int RF_NREGS  = 16;
  localparam int RF_PC_IDX = 15;

  function automatic logic is_pc(input logic [RF_AW-1:0] addr);
    return addr == RF_AW'(RF_PC_IDX);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and issue stage (master) and the arbiter (slave).
interface regfile_wb_arbiter_if #(parameter int NREQ = 2) ();
  import regfile_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*RF_AW-1:0] req_addr;
  logic [NREQ*RF_DW-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  claim_valid;
  logic [RF_AW-1:0]      claim_addr;
  logic                  wEn1;
  logic [RF_AW-1:0]      wA1;
  logic [RF_DW-1:0]      wD1;
  logic [RF_NREGS-1:0]   busy;
  logic                  r15_drop;

  modport master (
    output req_valid, req_addr, req_data, claim_valid, claim_addr,
    input  req_ready, wEn1, wA1, wD1, busy, r15_drop
  );

  modport slave (
    input  req_valid, req_addr, req_data, claim_valid, claim_addr,
    output req_ready, wEn1, wA1, wD1, busy, r15_drop
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that moves
// past the winner whenever advance is strobed.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  // Two passes: indices at or above the pointer first, then wrap to the bottom.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (PW'(j) >= ptr)) begin
        grant[j] = 1'b1;
        gnt_idx  = PW'(j);
        found    = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        gnt_idx  = PW'(j);
        found    = 1'b1;
      end
    end
  end

  assign ptr_nxt = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources, tracks outstanding
// destinations for RAW stalls, and discards writes aimed at the PC counter (r15).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  logic [NREQ-1:0]     grant;
  logic                hs;
  logic [RF_AW-1:0]    sel_addr;
  logic [RF_DW-1:0]    sel_data;
  logic [RF_NREGS-1:0] busy_nxt;

  // The register file never back-pressures, so any valid request completes this cycle.
  assign hs = |bus.req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*RF_AW +: RF_AW];
        sel_data = bus.req_data[i*RF_DW +: RF_DW];
      end
    end
  end

  // Clear applied before set so a same-cycle claim keeps the bit for the newer producer.
  always_comb begin
    busy_nxt = bus.busy;
    if (bus.wEn1) begin
      busy_nxt[bus.wA1] = 1'b0;
    end
    if (bus.claim_valid && !is_pc(bus.claim_addr)) begin
      busy_nxt[bus.claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wEn1     <= 1'b0;
      bus.wA1      <= '0;
      bus.wD1      <= '0;
      bus.busy     <= '0;
      bus.r15_drop <= 1'b0;
    end else begin
      bus.busy     <= busy_nxt;
      bus.wEn1     <= hs && !is_pc(sel_addr);
      bus.r15_drop <= hs && is_pc(sel_addr);
      if (hs) begin
        bus.wA1 <= sel_addr;
        bus.wD1 <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized
// run against a round-robin / scoreboard reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int mdl_ptr = 0;
  logic [31:0] rf [16];

  // Register-file model: r15 free-runs unless something wrongly writes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) rf[r] <= '0;
    end else begin
      for (int r = 0; r < 15; r++) if (bus.wEn1 && bus.wA1 == 4'(r)) rf[r] <= bus.wD1;
      rf[15] <= (bus.wEn1 && bus.wA1 == 4'd15) ? bus.wD1 : rf[15] + 32'd1;
    end
  end

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mdl_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.claim_valid = 1'b0;
    bus.claim_addr  = '0;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i*RF_AW +: RF_AW] = a;
    bus.req_data[i*RF_DW +: RF_DW] = d;
  endtask

  task automatic note_hs(input int g);
    if (g >= 0) mdl_ptr = (g + 1) % NREQ;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    tests++; if (bus.wEn1 !== 1'b0) begin fails++; $display("FAIL reset_wen got=%b exp=0", bus.wEn1); end
    tests++; if (bus.wA1 !== 4'h0) begin fails++; $display("FAIL reset_wa got=%0h exp=0", bus.wA1); end
    tests++; if (bus.wD1 !== 32'h0) begin fails++; $display("FAIL reset_wd got=%0h exp=0", bus.wD1); end
    tests++; if (bus.busy !== 16'h0) begin fails++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
    tests++; if (bus.r15_drop !== 1'b0) begin fails++; $display("FAIL reset_drop got=%b exp=0", bus.r15_drop); end
    tests++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 0;
    step();
  endtask

  task automatic test_single_write();
    int g;
    clear_inputs();
    set_req(0, 4'd3, 32'hDEADBEEF);
    #1;
    g = exp_grant(bus.req_valid);
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
    note_hs(g);
    step();
    clear_inputs();
    #1;
    tests++; if (bus.wEn1 !== 1'b1) begin fails++; $display("FAIL single_wen got=%b exp=1", bus.wEn1); end
    tests++; if (bus.wA1 !== 4'd3) begin fails++; $display("FAIL single_wa got=%0d exp=3", bus.wA1); end
    tests++; if (bus.wD1 !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wd got=%0h exp=deadbeef", bus.wD1); end
    tests++; if (bus.r15_drop !== 1'b0) begin fails++; $display("FAIL single_drop got=%b exp=0", bus.r15_drop); end
    step();
    tests++; if (rf[3] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rf3 got=%0h exp=deadbeef", rf[3]); end
    tests++; if (bus.wEn1 !== 1'b0) begin fails++; $display("FAIL single_wen_after got=%b exp=0", bus.wEn1); end
    tests++; if (bus.wA1 !== 4'd3) begin fails++; $display("FAIL single_wa_hold got=%0d exp=3", bus.wA1); end
    tests++; if (bus.wD1 !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wd_hold got=%0h exp=deadbeef", bus.wD1); end
  endtask

  task automatic test_contention();
    logic [3:0]  ga;
    logic [31:0] gd;
    logic [NREQ-1:0] exp_r;
    int g;
    clear_inputs();
    set_req(1, 4'd1, $urandom);
    #1;
    g = exp_grant(bus.req_valid);
    tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL cont_pre_ready got=%b exp=10", bus.req_ready); end
    note_hs(g);
    step();
    set_req(0, 4'($urandom_range(14, 0)), $urandom);
    set_req(1, 4'($urandom_range(14, 0)), $urandom);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
      g = (c % 2 == 0) ? 0 : 1;
      tests++; if (bus.req_ready !== exp_r) begin fails++; $display("FAIL cont_grant%0d got=%b exp=%b", c, bus.req_ready, exp_r); end
      ga = bus.req_addr[g*RF_AW +: RF_AW];
      gd = bus.req_data[g*RF_DW +: RF_DW];
      note_hs(g);
      step();
      tests++; if (bus.wEn1 !== 1'b1 || bus.wA1 !== ga || bus.wD1 !== gd) begin
        fails++; $display("FAIL cont_write%0d got=%b/%0h/%0h exp=1/%0h/%0h", c, bus.wEn1, bus.wA1, bus.wD1, ga, gd);
      end
      set_req(g, 4'($urandom_range(14, 0)), $urandom);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd5;
    #1;
    tests++; if (bus.busy[5] !== 1'b0) begin fails++; $display("FAIL sb_c0 got=%b exp=0", bus.busy[5]); end
    step(); clear_inputs(); #1;
    tests++; if (bus.busy[5] !== 1'b1) begin fails++; $display("FAIL sb_c1 got=%b exp=1", bus.busy[5]); end
    step();
    tests++; if (bus.busy[5] !== 1'b1) begin fails++; $display("FAIL sb_c2 got=%b exp=1", bus.busy[5]); end
    step();
    set_req(0, 4'd5, $urandom);
    #1;
    tests++; if (bus.busy[5] !== 1'b1) begin fails++; $display("FAIL sb_c3 got=%b exp=1", bus.busy[5]); end
    note_hs(exp_grant(bus.req_valid));
    step(); clear_inputs(); #1;
    tests++; if (bus.busy[5] !== 1'b1 || bus.wEn1 !== 1'b1) begin fails++; $display("FAIL sb_c4 got=%b/%b exp=1/1", bus.busy[5], bus.wEn1); end
    step();
    tests++; if (bus.busy[5] !== 1'b0) begin fails++; $display("FAIL sb_c5 got=%b exp=0", bus.busy[5]); end
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd7;
    set_req(0, 4'd7, $urandom);
    #1;
    note_hs(exp_grant(bus.req_valid));
    step();
    bus.req_valid = '0;
    #1;
    tests++; if (bus.wEn1 !== 1'b1 || bus.wA1 !== 4'd7) begin fails++; $display("FAIL sb_r7_write got=%b/%0d exp=1/7", bus.wEn1, bus.wA1); end
    step();
    clear_inputs();
    #1;
    tests++; if (bus.busy[7] !== 1'b1) begin fails++; $display("FAIL sb_r7_claim_wins got=%b exp=1", bus.busy[7]); end
    set_req(0, 4'd7, $urandom);
    #1;
    note_hs(exp_grant(bus.req_valid));
    step(); clear_inputs();
    step();
    tests++; if (bus.busy[7] !== 1'b0) begin fails++; $display("FAIL sb_r7_cleared got=%b exp=0", bus.busy[7]); end
  endtask

  task automatic test_r15_filter();
    logic [31:0] r0;
    clear_inputs();
    set_req(1, 4'd15, $urandom);
    #1;
    tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL r15_ready got=%b exp=10", bus.req_ready); end
    note_hs(exp_grant(bus.req_valid));
    r0 = rf[15];
    step(); clear_inputs();
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd15;
    #1;
    tests++; if (bus.wEn1 !== 1'b0) begin fails++; $display("FAIL r15_wen got=%b exp=0", bus.wEn1); end
    tests++; if (bus.r15_drop !== 1'b1) begin fails++; $display("FAIL r15_drop got=%b exp=1", bus.r15_drop); end
    step(); clear_inputs(); #1;
    tests++; if (bus.r15_drop !== 1'b0) begin fails++; $display("FAIL r15_drop_pulse got=%b exp=0", bus.r15_drop); end
    tests++; if (rf[15] !== r0 + 32'd2) begin fails++; $display("FAIL r15_count got=%0h exp=%0h", rf[15], r0 + 32'd2); end
    tests++; if (bus.busy[15] !== 1'b0) begin fails++; $display("FAIL r15_claim got=%b exp=0", bus.busy[15]); end
  endtask

  task automatic test_idle();
    int saved;
    int sel;
    clear_inputs();
    saved = mdl_ptr;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (bus.wEn1 !== 1'b0 || bus.req_ready !== '0) begin
        fails++; $display("FAIL idle%0d got=%b/%b exp=0/0", c, bus.wEn1, bus.req_ready);
      end
    end
    step();
    set_req(0, 4'($urandom_range(14, 0)), $urandom);
    set_req(1, 4'($urandom_range(14, 0)), $urandom);
    #1;
    tests++; if (bus.req_ready !== onehot(saved)) begin fails++; $display("FAIL idle_ptr got=%b exp=%b", bus.req_ready, onehot(saved)); end
    note_hs(saved);
    step(); clear_inputs();
    sel = $urandom_range(NREQ - 1, 0);
    set_req(sel, 4'($urandom_range(14, 0)), $urandom);
    #1;
    tests++; if (bus.req_ready !== onehot(sel)) begin fails++; $display("FAIL idle_single got=%b exp=%b", bus.req_ready, onehot(sel)); end
    note_hs(sel);
    step(); clear_inputs();
    step();
  endtask

  task automatic test_random();
    logic            pend [NREQ];
    logic [3:0]      pa   [NREQ];
    logic [31:0]     pd   [NREQ];
    int              wait_cnt [NREQ];
    logic [15:0]     mdl_busy;
    logic            exp_wen, exp_drop;
    logic [3:0]      exp_wa;
    logic [31:0]     exp_wd;
    logic            cv;
    logic [3:0]      ca;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] rdy;
    int              g;
    int              errs;
    clear_inputs();
    step();
    errs = fails;
    mdl_busy = bus.busy;
    exp_wen = 1'b0; exp_drop = 1'b0; exp_wa = '0; exp_wd = '0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; wait_cnt[i] = 0; pa[i] = '0; pd[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) step();
      v = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom_range(14, 0));
          pd[i] = $urandom;
        end
        v[i] = pend[i];
        bus.req_addr[i*RF_AW +: RF_AW] = pa[i];
        bus.req_data[i*RF_DW +: RF_DW] = pd[i];
      end
      bus.req_valid = v;
      cv = ($urandom % 3 == 0);
      ca = 4'($urandom_range(15, 0));
      bus.claim_valid = cv;
      bus.claim_addr  = ca;
      #1;
      tests++; if (bus.wEn1 !== exp_wen) begin fails++; $display("FAIL rnd_wen c%0d got=%b exp=%b", cyc, bus.wEn1, exp_wen); end
      if (exp_wen) begin
        tests++; if (bus.wA1 !== exp_wa || bus.wD1 !== exp_wd) begin
          fails++; $display("FAIL rnd_wdata c%0d got=%0h/%0h exp=%0h/%0h", cyc, bus.wA1, bus.wD1, exp_wa, exp_wd);
        end
      end
      tests++; if (bus.r15_drop !== exp_drop) begin fails++; $display("FAIL rnd_drop c%0d got=%b exp=%b", cyc, bus.r15_drop, exp_drop); end
      tests++; if (bus.busy !== mdl_busy) begin fails++; $display("FAIL rnd_busy c%0d got=%0h exp=%0h", cyc, bus.busy, mdl_busy); end
      g = exp_grant(v);
      rdy = bus.req_ready;
      tests++; if (rdy !== onehot(g)) begin fails++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, rdy, onehot(g)); end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && rdy[i] !== 1'b1) begin
          wait_cnt[i]++;
          tests++; if (wait_cnt[i] > NREQ - 1) begin fails++; $display("FAIL rnd_starve c%0d req%0d waited=%0d max=%0d", cyc, i, wait_cnt[i], NREQ - 1); end
        end
      end
      if (exp_wen) mdl_busy[exp_wa] = 1'b0;
      if (cv && ca != 4'd15) mdl_busy[ca] = 1'b1;
      if (g >= 0) begin
        exp_wen  = (pa[g] != 4'd15);
        exp_drop = (pa[g] == 4'd15);
        exp_wa   = pa[g];
        exp_wd   = pd[g];
        note_hs(g);
      end else begin
        exp_wen  = 1'b0;
        exp_drop = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && rdy[i] === 1'b1) begin pend[i] = 1'b0; wait_cnt[i] = 0; end
      end
      if (fails - errs > 20) break;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    bus.claim_valid = 1'b1; bus.claim_addr = 4'd9;
    set_req(0, 4'd9, 32'h12345678);
    #1;
    note_hs(exp_grant(bus.req_valid));
    step(); clear_inputs(); #1;
    tests++; if (bus.wEn1 !== 1'b1 || bus.busy[9] !== 1'b1) begin fails++; $display("FAIL arst_pre got=%b/%b exp=1/1", bus.wEn1, bus.busy[9]); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.wEn1 !== 1'b0) begin fails++; $display("FAIL arst_wen got=%b exp=0", bus.wEn1); end
    tests++; if (bus.busy !== 16'h0) begin fails++; $display("FAIL arst_busy got=%0h exp=0", bus.busy); end
    tests++; if (bus.wA1 !== 4'h0 || bus.wD1 !== 32'h0) begin fails++; $display("FAIL arst_wdata got=%0h/%0h exp=0/0", bus.wA1, bus.wD1); end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 0;
    step();
    tests++; if (bus.wEn1 !== 1'b0 || rf[9] === 32'h12345678) begin fails++; $display("FAIL arst_lost got=%b/%0h exp=0/not12345678", bus.wEn1, rf[9]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_scoreboard();
    test_r15_filter();
    test_idle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
